// File: rtl/regfile_dump_pkg.sv
// Shared defaults and FSM state type for the register-file dump engine.
// Optional trailing checksum word is enabled by defining REGDUMP_CHECKSUM_EN.
package regfile_dump_pkg;

  localparam int unsigned DEF_NUM_REGS = 16;
  localparam int unsigned DEF_ADDR_W   = 4;
  localparam int unsigned DEF_DATA_W   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StCsum,
    StDone
  } state_e;

endpackage

// File: rtl/dump_checksum.sv
// Clear/accumulate/hold adder producing the running checksum of dumped words.
// The module only exists when REGDUMP_CHECKSUM_EN is defined; otherwise this
// file elaborates to nothing so the default build carries no accumulator.
`ifdef REGDUMP_CHECKSUM_EN
module dump_checksum
  import regfile_dump_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_acc,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  // Running sum modulo 2^DATA_W; clear has priority over accumulate.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_acc) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule
`endif

// File: rtl/regfile_dump.sv
// Sequential read-out engine: sweeps register indices 0..NUM_REGS-1 through one
// register-file read port and streams each word over valid/ready.
// Define REGDUMP_CHECKSUM_EN to append a checksum word after the last register.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rd_code,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_index,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_rd_code;
  logic [DATA_W-1:0] r_out_data;
  logic              w_valid;
  logic              w_hs;
  logic              w_is_last;

  assign w_valid   = (r_state == StSend) || (r_state == StCsum);
  assign w_hs      = w_valid & i_out_ready;
  assign w_is_last = (r_rd_code == LastIdx);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StFetch;
      end
      StFetch: begin
        w_state_next = StSend;
      end
      StSend: begin
        if (w_hs && w_is_last) begin
`ifdef REGDUMP_CHECKSUM_EN
          w_state_next = StCsum;
`else
          w_state_next = StDone;
`endif
        end else if (w_hs) begin
          w_state_next = StFetch;
        end
      end
      StCsum: begin
        if (w_hs) w_state_next = StDone;
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
    if (i_abort && (r_state != StIdle)) w_state_next = StIdle;
  end

  // Read index and captured word; rd_data is only sampled while fetching.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_code  <= '0;
      r_out_data <= '0;
    end else begin
      if ((r_state == StIdle) && i_start) begin
        r_rd_code <= '0;
      end else if ((r_state == StSend) && w_hs && !w_is_last && !i_abort) begin
        r_rd_code <= r_rd_code + ADDR_W'(1);
      end
      if (r_state == StFetch) begin
        r_out_data <= i_rd_data;
      end
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] w_csum;

  dump_checksum #(
    .DATA_W (DATA_W)
  ) u_dump_checksum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear ((r_state == StIdle) && i_start),
    .i_acc   (r_state == StFetch),
    .i_data  (i_rd_data),
    .o_sum   (w_csum)
  );

  assign o_out_data = (r_state == StCsum) ? w_csum : r_out_data;
  assign o_out_last = (r_state == StCsum);
`else
  assign o_out_data = r_out_data;
  assign o_out_last = (r_state == StSend) && w_is_last;
`endif

  // In the checksum state the index stays parked at the last register.
  assign o_rd_code   = r_rd_code;
  assign o_out_index = r_rd_code;
  assign o_out_valid = w_valid;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StDone);

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: stimulus pushes expected words computed
// from a plain register array; a negedge monitor pops and compares on handshake.
module tb_regfile_dump;

  localparam int N = 16;
`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif
  localparam int DoneRel = CsumEn ? 2 * N + 2 : 2 * N + 1;
  localparam int Budget  = 120;

  localparam int ModeNorm  = 0;
  localparam int ModeStall = 1;
  localparam int ModeStart = 2;
  localparam int ModeAbort = 3;
  localparam int ModeRst   = 4;
  localparam int ModeWr9   = 5;
  localparam int ModeRand  = 6;

  localparam logic [15:0] PRELOAD [N] = '{
    16'h1234, 16'h0000, 16'hffff, 16'h1337, 16'h0231, 16'hdead, 16'hbeef, 16'hf00f,
    16'hb00b, 16'hc0de, 16'h4321, 16'h8000, 16'h0919, 16'h1995, 16'h1028, 16'h2014
  };
  localparam logic [3:0] RDY_PAT = 4'b1001;  // cycle order 1,0,0,1

  typedef struct {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready;
  logic [3:0]  rd_code, out_index;
  logic [15:0] rd_data, out_data;
  logic        out_valid, out_last, busy, done;
  logic [15:0] regs [N];

  exp_t exp_q[$];
  int   done_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   stall_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign rd_data = regs[rd_code];

  regfile_dump u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .o_rd_code   (rd_code),
    .i_rd_data   (rd_data),
    .o_out_data  (out_data),
    .o_out_index (out_index),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare every accepted word, output stability under stall, and done timing.
  logic        was_stalled = 1'b0;
  logic [15:0] hold_data;
  logic [3:0]  hold_idx;
  logic        hold_last;
  int          mon_rel;
  exp_t        mon_e;
  always @(negedge clk) begin
    mon_rel = cyc - t_start;
    if (out_valid) begin
      chk("busy_while_valid", {31'd0, busy}, 32'd1);
      if (was_stalled) begin
        chk("stall_hold_data", {16'd0, out_data}, {16'd0, hold_data});
        chk("stall_hold_index", {28'd0, out_index}, {28'd0, hold_idx});
        chk("stall_hold_last", {31'd0, out_last}, {31'd0, hold_last});
      end
      if (out_ready) begin
        was_stalled = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_word: got index %0d data %h, required no word", out_index, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word_data", {16'd0, out_data}, {16'd0, mon_e.data});
          chk("word_index", {28'd0, out_index}, {28'd0, mon_e.idx});
          chk("word_last", {31'd0, out_last}, {31'd0, mon_e.last});
          if (mon_e.cyc >= 0) chk("word_cycle", mon_rel, mon_e.cyc);
        end
      end else begin
        was_stalled = 1'b1;
        hold_data   = out_data;
        hold_idx    = out_index;
        hold_last   = out_last;
        stall_cnt++;
      end
    end else begin
      was_stalled = 1'b0;
    end
    if (done) begin
      if (done_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required 0", mon_rel);
      end else begin
        chk("done_cycle", mon_rel - stall_cnt, done_q.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_code"}, {28'd0, rd_code}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    chk({tag, "_out_index"}, {28'd0, out_index}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // One dump: expected stream comes from the register array as it will be seen
  // at each fetch; checksum is the plain 16-bit wraparound sum of those words.
  task automatic run(input int mode);
    logic [15:0] plan [N];
    int          sum;
    int          nw;
    bit          full;
    bit          timed;
    for (int k = 0; k < N; k++) plan[k] = regs[k];
    if (mode == ModeWr9) plan[9] = 16'h0000;
    full  = (mode != ModeAbort) && (mode != ModeRst);
    timed = (mode != ModeStall) && (mode != ModeRand);
    nw    = (mode == ModeAbort) ? 5 : (mode == ModeRst) ? 4 : N;
    sum   = 0;
    for (int k = 0; k < N; k++) sum += int'(plan[k]);

    @(posedge clk);
    #1;
    t_start   = cyc;
    stall_cnt = 0;
    for (int k = 0; k < nw; k++) begin
      exp_q.push_back('{plan[k], 4'(k), (!CsumEn) && (k == N - 1), timed ? 2 + 2 * k : -1});
    end
    if (CsumEn && full) exp_q.push_back('{16'(sum), 4'(N - 1), 1'b1, timed ? 2 * N + 1 : -1});
    if (full) done_q.push_back(DoneRel);

    for (int rel = 0; rel < Budget; rel++) begin
      if (rel > 0) begin
        @(posedge clk);
        #1;
      end
      start = (rel == 0) || ((mode == ModeStart) && (rel == 5));
      abort = (mode == ModeAbort) && (rel == 10);
      rst_n = !((mode == ModeRst) && (rel == 9));
      if (mode == ModeStall) out_ready = RDY_PAT[3 - (rel % 4)];
      else if (mode == ModeRand) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
      // Write lands on the edge ending the cycle before register 9's fetch.
      if ((mode == ModeWr9) && (rel == 19)) regs[9] = 16'h0000;
      if ((mode == ModeAbort) && (rel == 11)) begin
        @(negedge clk);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
      end
      if ((mode == ModeRst) && (rel == 10)) begin
        @(negedge clk);
        check_reset_outputs("midreset");
      end
    end
    start     = 1'b0;
    abort     = 1'b0;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk("words_drained", exp_q.size(), 32'd0);
    chk("done_drained", done_q.size(), 32'd0);
    exp_q.delete();
    done_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) regs[k] = PRELOAD[k];
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run(ModeNorm);
    run(ModeStall);
    run(ModeStart);
    run(ModeAbort);
    run(ModeNorm);
    run(ModeRst);
    run(ModeNorm);
    run(ModeWr9);
    regs[9] = PRELOAD[9];
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) regs[k] = 16'($urandom);
      run(ModeRand);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine that sits on the read side of the 16 × 16-bit register file. On command it sweeps register indices 0..NUM_REGS-1 through one register-file read port and streams each word out over a valid/ready interface, e.g. to a debug UART or trace buffer. It is the initiator on that read port; the register file's write port stays owned by the datapath.

## Interface
- NUM_REGS, 16, number of registers swept
- ADDR_W, 4, register index width
- DATA_W, 16, register word width
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  cancel an in-progress dump
- rd_code  out  ADDR_W  index driven onto the register-file read port (reg1)
- rd_data  in  DATA_W  combinational register-file read data (read1)
- out_data  out  DATA_W  streamed word
- out_index  out  ADDR_W  register index of out_data
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts the word
- out_last  out  1  final word of the dump
- busy  out  1  dump in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, FETCH, SEND, CSUM (only with the macro), DONE.
- IDLE: start=1 → FETCH with rd_code=0, checksum cleared.
- FETCH: one cycle. rd_data is captured into out_data at the end of the cycle, then → SEND.
- SEND: out_valid=1. out_data and out_index are held stable until out_valid & out_ready.
  - On handshake with rd_code<NUM_REGS-1: increment rd_code and go to FETCH.
  - On handshake with rd_code==NUM_REGS-1: go to CSUM if the macro is defined, otherwise DONE.
- CSUM: out_data=checksum, out_index=NUM_REGS-1, out_valid=1, out_last=1. Handshake → DONE.
- DONE: done=1 for one cycle, then IDLE.
- out_last=1 with register NUM_REGS-1's word only when the macro is absent.
- busy=1 in every state except IDLE.
- start while busy is ignored.
- abort=1 in any non-IDLE state → IDLE next cycle. out_valid drops and done does not pulse.
  - If abort coincides with a handshake, the sink keeps that word and the FSM still goes to IDLE.
  - If start and abort coincide in IDLE, start wins.
- No atomicity. Each word reflects the register value during its own FETCH cycle, so writes that land mid-dump are visible for registers not yet fetched.
- rd_code wraps only by returning to 0 on the next start; it never increments past NUM_REGS-1.

## Timing
- Reset values: rd_code=0, out_data=0, out_index=0, out_valid=0, out_last=0, busy=0, done=0, state IDLE.
- Reset mid-dump: same values on the next edge. No partial out_last is emitted.
- Taking the cycle start is sampled as cycle 0, with out_ready held high:
  - word k is valid in cycle 2+2k, so register 15 is valid in cycle 32;
  - the checksum is valid in cycle 33, and done pulses in cycle 34;
  - without the macro, done pulses in cycle 33.
- Back-pressure: each cycle with out_ready=0 adds exactly one cycle. Outputs must not change while stalled.
- rd_data is sampled only in FETCH.

## Configuration
- Macro REGDUMP_CHECKSUM_EN.
- Defined: a running sum modulo 2^DATA_W of all captured words is kept and emitted as one extra trailing word carrying out_last.
- Undefined: no accumulator and no CSUM state. The dump is exactly NUM_REGS words.

## Structure
- Package regfile_dump_pkg holds:
  - the NUM_REGS, ADDR_W and DATA_W defaults;
  - the state enum (IDLE, FETCH, SEND, CSUM, DONE).
- One sub-module, dump_checksum: a clear/accumulate/hold adder, instantiated only under REGDUMP_CHECKSUM_EN.

## Test plan
- Preload registers with [1234, 0000, ffff, 1337, 0231, dead, beef, f00f, b00b, c0de, 4321, 8000, 0919, 1995, 1028, 2014], hold out_ready=1, pulse start:
  - 16 words in index order, word k in cycle 2+2k;
  - with the macro, a 17th word 3c3a with out_last;
  - done in cycle 34, or 33 without the macro.
- Same preload with out_ready toggling 1,0,0,1: stream content is identical, out_data is stable during stalls, and total latency grows by the stall count.
- start asserted again in cycle 5 → ignored, and the stream is unchanged.
- abort in cycle 10 → out_valid=0 and busy=0 the next cycle, no done. A following start restarts at index 0 with value 1234.
- rst_n=0 for one cycle mid-dump → all outputs return to reset values on the next edge.
- Write register 9 to 0000 during the cycle before its FETCH → the streamed word for index 9 is 0000. With the macro, the checksum becomes 7b5c.
